uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//   Receive side of the on-board UART: 8-N-1 serial in, LSB first, idle-high line.
//   Synchronizes the async RX pin, qualifies the start bit at mid-bit and samples each data bit at mid-bit.
//   Presents the received byte with a sticky ready flag, read and cleared by the CPU I/O port logic.
//   Pairs with uart_transmitter at the same CLOCK_SPEED/BAUD_RATE, so the two can be looped back.
// PARAMETERS
//   CLOCK_SPEED  200_000  system clock frequency in Hz
//   BAUD_RATE    9_600    serial bit rate
//   CLKS_PER_BIT  localparam = CLOCK_SPEED / BAUD_RATE (integer division, 20 at defaults); HALF_BIT = CLKS_PER_BIT/2
// PORTS
//   clk            in   1  system clock, rising edge
//   reset          in   1  asynchronous, active-high reset
//   data_in        in   1  serial RX line (asynchronous to clk, idle 1)
//   clear_strobe   in   1  1-clk pulse: CPU has consumed the byte; clears data_ready/frame_error/overrun_error
//   data_out       out  8  last correctly framed byte
//   data_ready     out  1  sticky: new byte valid in data_out
//   frame_error    out  1  sticky: stop bit sampled 0
//   overrun_error  out  1  sticky: byte completed while data_ready already 1
//   busy_flag      out  1  frame in progress (state != S_UART_RX_IDLE), combinational from state
// BEHAVIOUR
//   Reset: state=S_UART_RX_IDLE, sync flops=1, shift reg=0, bit counter=0, baud counter=0.
//     data_out=8'h00, data_ready=0, frame_error=0, overrun_error=0, busy_flag=0.
//   Sync: 2-flop synchronizer on data_in -> rx_sync; all decisions use rx_sync (2-clk input latency).
//   FSM:
//   - S_UART_RX_IDLE: rx_sync==0 -> S_UART_RX_START, baud counter cleared.
//   - S_UART_RX_START: count to HALF_BIT-1. At mid-bit: rx_sync==0 -> S_UART_RX_RECEIVE_DATA (counter=0, bit idx=0).
//     rx_sync==1 at mid-bit -> glitch: back to S_UART_RX_IDLE; no flag changes.
//   - S_UART_RX_RECEIVE_DATA: every CLKS_PER_BIT clks sample rx_sync and shift right, sample into bit 7 (LSB first).
//     After the 8th sample -> S_UART_RX_STOP.
//   - S_UART_RX_STOP: after CLKS_PER_BIT clks sample rx_sync.
//     Sample 1: data_out<=shift reg; data_ready<=1; overrun_error<=1 if data_ready was already 1.
//     Sample 0: frame_error<=1; data_out and data_ready unchanged.
//     In both cases -> S_UART_RX_IDLE on the same edge (mid stop bit), so back-to-back frames are accepted.
//   Counters: baud counter wide enough for CLKS_PER_BIT-1; wraps to 0 on each sample point. Bit index 3 bits, 0..7.
//   Flag/clear rules:
//   - clear_strobe clears data_ready, frame_error and overrun_error on the next edge.
//   - clear_strobe in the same cycle as a byte completion: set wins. data_ready=1, new data_out, no overrun.
//     The other flags are cleared.
//   - clear_strobe has no effect on the FSM, shift reg or data_out.
//   Latency: data_ready rises HALF_BIT + 9*CLKS_PER_BIT clks after rx_sync falls (190 at defaults),
//     plus the 2-clk sync.
//   Reset mid-frame: immediate return to IDLE with all outputs at reset values.
//     The partial byte is discarded; the next falling edge starts a fresh frame.
//   Line held low (break): frame_error set, then the FSM re-enters START while rx_sync stays 0.
//     Each further 10-bit period flags frame_error again; no data_ready.
// TESTING (20 clks/bit, bench drives data_in at bit boundaries)
//   1. Send 8'hA5 (bits 1,0,1,0,0,1,0,1 then stop=1) -> busy_flag=1 during frame.
//      data_ready=1 and data_out=8'hA5 ~192 clks after start edge; frame_error=0.
//   2. 5-clk low pulse on idle line -> state returns S_UART_RX_IDLE by clk 12.
//      data_ready=0, data_out unchanged, busy_flag=0.
//   3. Send 8'h3C with stop bit driven 0 -> frame_error=1, data_ready=0, data_out=8'h00.
//      clear_strobe -> frame_error=0.
//   4. Back-to-back 8'h3C then 8'hC3 with no clear -> data_out=8'hC3, data_ready=1, overrun_error=1.
//      clear_strobe -> all three flags 0.
//   5. clear_strobe pulsed in the exact completion cycle of 8'h5A (ready already 1 from prior byte)
//      -> data_ready=1, data_out=8'h5A, overrun_error=0.
//   6. Assert reset after 4 data bits of 8'hFF, release -> all outputs at reset values.
//      Next full frame 8'h81 received correctly.
//   Loopback: uart_transmitter.data_out -> data_in, transmit 8'hAA -> receiver data_out=8'hAA, data_ready=1.

Source files
------------

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial RX line, CPU clear strobe and received-byte status.
// master = CPU/line side (drives data_in, clear_strobe); slave = receiver.
`timescale 1ns/1ps

interface uart_receiver_if;
  logic       data_in;
  logic       clear_strobe;
  logic [7:0] data_out;
  logic       data_ready;
  logic       frame_error;
  logic       overrun_error;
  logic       busy_flag;

  modport master (
    output data_in,
    output clear_strobe,
    input  data_out,
    input  data_ready,
    input  frame_error,
    input  overrun_error,
    input  busy_flag
  );

  modport slave (
    input  data_in,
    input  clear_strobe,
    output data_out,
    output data_ready,
    output frame_error,
    output overrun_error,
    output busy_flag
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8-N-1 UART receive path, LSB first, idle-high line.
// Ports: clk, reset (async, active high), bus (uart_receiver_if.slave):
//   data_in, clear_strobe in; data_out[7:0], data_ready, frame_error,
//   overrun_error, busy_flag out.
`timescale 1ns/1ps

module uart_receiver #(
  parameter int CLOCK_SPEED = 200_000,
  parameter int BAUD_RATE   = 9_600
) (
  input  logic           clk,
  input  logic           reset,
  uart_receiver_if.slave bus
);

  localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] LAST_CNT =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT =
    CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    S_UART_RX_IDLE,
    S_UART_RX_START,
    S_UART_RX_RECEIVE_DATA,
    S_UART_RX_STOP
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q;
  logic          rx_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    dout_q, dout_d;
  logic          rdy_q, rdy_d;
  logic          ferr_q, ferr_d;
  logic          oerr_q, oerr_d;

  // Two-flop synchronizer; idles high like the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.data_in;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_UART_RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    // Clear strobe drops the sticky flags unless a set below wins.
    rdy_d   = rdy_q  & ~bus.clear_strobe;
    ferr_d  = ferr_q & ~bus.clear_strobe;
    oerr_d  = oerr_q & ~bus.clear_strobe;

    unique case (state_q)
      S_UART_RX_IDLE: begin
        if (!rx_sync_q) begin
          state_d = S_UART_RX_START;
          cnt_d   = '0;
        end
      end

      S_UART_RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_sync_q) begin
            state_d = S_UART_RX_RECEIVE_DATA;
            idx_d   = '0;
          end else begin
            // Start bit gone by mid-bit: glitch.
            state_d = S_UART_RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_UART_RX_RECEIVE_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
            state_d = S_UART_RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_UART_RX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          // Leave mid stop bit so a back-to-back
          // start edge is not missed.
          state_d = S_UART_RX_IDLE;
          if (rx_sync_q) begin
            dout_d = shift_q;
            rdy_d  = 1'b1;
            // A byte consumed this cycle is no overrun.
            oerr_d = oerr_d
                   | (rdy_q & ~bus.clear_strobe);
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_UART_RX_IDLE;
      end
    endcase
  end

  assign bus.data_out      = dout_q;
  assign bus.data_ready    = rdy_q;
  assign bus.frame_error   = ferr_q;
  assign bus.overrun_error = oerr_q;
  assign bus.busy_flag     = (state_q != S_UART_RX_IDLE);

endmodule
